key_tone_controller: RTL

Sequencer between the PS/2 byte receiver and the audio output path of the keyboard-synth design. It consumes received scancode bytes, tracks make and break codes, and selects one of eight notes from the top letter row. It runs the note's square-wave oscillator and paces sample writes to the audio codec with a one-cycle `wr` strobe at a fixed sample rate.

---
 rtl/key_tone_pkg.sv | 43 ++++
 rtl/key_tone_controller_if.sv | 28 ++
 rtl/tone_generator.sv | 50 +++++
 rtl/key_tone_controller.sv | 118 +++++++++++
 4 files changed

// File: rtl/key_tone_pkg.sv
`default_nettype none
// ============================================================================
// Package : key_tone_pkg
// Brief   : Scancode constants, FSM state type and the key-to-note lookup.
// Rev     : 1.0 - initial release
// ============================================================================
package key_tone_pkg;

    localparam int NOTE_W = 4;
    localparam int HALF_W = 17;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BREAK = 1'b1
    } kbd_state_e;

    typedef struct packed {
        logic [NOTE_W-1:0] index;
        logic [HALF_W-1:0] half;
    } note_info_t;

    // Index 0 marks an unmapped byte; half-periods are in system clocks at 50 MHz.
    function automatic note_info_t note_lookup(input logic [7:0] code);
        note_info_t info;
        case (code)
            8'h15:   info = '{index: 4'd1, half: 17'd95556};
            8'h1D:   info = '{index: 4'd2, half: 17'd85131};
            8'h24:   info = '{index: 4'd3, half: 17'd75843};
            8'h2D:   info = '{index: 4'd4, half: 17'd71586};
            8'h2C:   info = '{index: 4'd5, half: 17'd63776};
            8'h35:   info = '{index: 4'd6, half: 17'd56818};
            8'h3C:   info = '{index: 4'd7, half: 17'd50619};
            8'h43:   info = '{index: 4'd8, half: 17'd47778};
            default: info = '0;
        endcase
        return info;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_tone_controller_if.sv
`default_nettype none
// ============================================================================
// Interface : key_tone_controller_if
// Brief     : PS/2 byte input and codec sample output of the tone controller.
// Rev       : 1.0 - initial release
// ============================================================================
interface key_tone_controller_if;
    import key_tone_pkg::*;

    logic              valid_data;
    logic [7:0]        data;
    logic [15:0]       square_wave;
    logic              wr;
    logic [NOTE_W-1:0] note;
    logic              active;

    modport master (
        output valid_data, data,
        input  square_wave, wr, note, active
    );

    modport slave (
        input  valid_data, data,
        output square_wave, wr, note, active
    );

endinterface
`default_nettype wire

// File: rtl/tone_generator.sv
`default_nettype none
// ============================================================================
// Module : tone_generator
// Brief  : Half-period counter and phase flip-flop of the note oscillator.
// Rev    : 1.0 - initial release
// ============================================================================
module tone_generator
    import key_tone_pkg::*;
(
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic [HALF_W-1:0] half_period,
    input  wire logic              restart,
    input  wire logic              enable,
    output logic                   phase
);

    logic [HALF_W-1:0] cnt_q, cnt_d;
    logic              phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == half_period - HALF_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + HALF_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule
`default_nettype wire

// File: rtl/key_tone_controller.sv
`default_nettype none
// ============================================================================
// Module : key_tone_controller
// Brief  : Scancode make/break tracking, note selection and paced sample writes.
// Rev    : 1.0 - initial release
// ============================================================================
module key_tone_controller
    import key_tone_pkg::*;
#(
    parameter int          SAMPLE_DIV = 1042,
    parameter logic [15:0] AMPLITUDE  = 16'h2000
) (
    input  wire logic              clock,
    input  wire logic              reset,
    key_tone_controller_if.slave   bus
);

    localparam int                DIV_W    = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [15:0]       AMP_NEG  = ~AMPLITUDE + 16'd1;

    kbd_state_e        state_q, state_d;
    logic [7:0]        held_code_q, held_code_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic              active_q, active_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              wr_q, wr_d;
    logic [15:0]       square_wave_q, square_wave_d;
    note_info_t        key;
    logic              phase;

    always_comb begin
        key         = note_lookup(bus.data);
        state_d     = state_q;
        held_code_d = held_code_q;
        note_d      = note_q;
        half_d      = half_q;
        if (bus.valid_data) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.data == SC_BREAK) begin
                        state_d = ST_BREAK;
                    end else if (bus.data != SC_EXT && key.index != '0 &&
                                 bus.data != held_code_q) begin
                        held_code_d = bus.data;
                        note_d      = key.index;
                        half_d      = key.half;
                    end
                end
                ST_BREAK: begin
                    // A break for a key that is no longer held just closes the sequence.
                    if (bus.data != SC_BREAK) begin
                        state_d = ST_IDLE;
                        if (bus.data == held_code_q) begin
                            note_d      = '0;
                            held_code_d = '0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        active_d = (note_d != '0);
    end

    // wr is registered so that it is high for exactly the cycle the divider sits on its last count.
    always_comb begin
        div_d         = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        wr_d          = (div_d == DIV_LAST);
        square_wave_d = square_wave_q;
        if (wr_d) begin
            if (note_q == '0) begin
                square_wave_d = '0;
            end else begin
                square_wave_d = phase ? AMPLITUDE : AMP_NEG;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            held_code_q   <= '0;
            note_q        <= '0;
            half_q        <= '0;
            active_q      <= 1'b0;
            div_q         <= '0;
            wr_q          <= 1'b0;
            square_wave_q <= '0;
        end else begin
            state_q       <= state_d;
            held_code_q   <= held_code_d;
            note_q        <= note_d;
            half_q        <= half_d;
            active_q      <= active_d;
            div_q         <= div_d;
            wr_q          <= wr_d;
            square_wave_q <= square_wave_d;
        end
    end

    tone_generator u_tone (
        .clock       (clock),
        .reset       (reset),
        .half_period (half_q),
        .restart     (note_d != note_q),
        .enable      (note_q != '0),
        .phase       (phase)
    );

    assign bus.square_wave = square_wave_q;
    assign bus.wr          = wr_q;
    assign bus.note        = note_q;
    assign bus.active      = active_q;

endmodule
`default_nettype wire
